// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and multdiv sequencing.
// Optional multdiv watchdog enabled by defining HAZARD_CTRL_WATCHDOG_EN.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] fd_insn,
  input  logic [31:0] dx_insn,
  input  logic        branch_taken,
  input  logic        md_ready,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        flush_fd,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        md_start,
  output logic        md_result_sel,
  output logic        md_timeout
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1,
    MD_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [4:0] w_fd_op, w_fd_rd, w_fd_rs, w_fd_rt, w_fd_aluop;
  logic [4:0] w_dx_op, w_dx_rd, w_dx_aluop;
  logic       w_fd_uses_rs, w_fd_uses_rt, w_fd_uses_rd;
  logic       w_load_use, w_md_op, w_wd_expire;

  assign w_fd_op    = fd_insn[31:27];
  assign w_fd_rd    = fd_insn[26:22];
  assign w_fd_rs    = fd_insn[21:17];
  assign w_fd_rt    = fd_insn[16:12];
  assign w_fd_aluop = fd_insn[6:2];
  assign w_dx_op    = dx_insn[31:27];
  assign w_dx_rd    = dx_insn[26:22];
  assign w_dx_aluop = dx_insn[6:2];

  // Store data read from sw's rd is forwarded W->M, so it never needs a stall.
  assign w_fd_uses_rs = (w_fd_op == OP_R) || (w_fd_op == OP_ADDI) || (w_fd_op == OP_LW) ||
                        (w_fd_op == OP_SW) || (w_fd_op == OP_BNE) || (w_fd_op == OP_BLT);
  assign w_fd_uses_rt = (w_fd_op == OP_R) && (w_fd_aluop[4:1] != 4'b0010);
  assign w_fd_uses_rd = (w_fd_op == OP_BNE) || (w_fd_op == OP_BLT) || (w_fd_op == OP_JR);

  assign w_load_use = (w_dx_op == OP_LW) && (w_dx_rd != 5'd0) &&
                      ((w_fd_uses_rs && (w_fd_rs == w_dx_rd)) ||
                       (w_fd_uses_rt && (w_fd_rt == w_dx_rd)) ||
                       (w_fd_uses_rd && (w_fd_rd == w_dx_rd)));

  assign w_md_op = (w_dx_op == OP_R) && ((w_dx_aluop == ALU_MUL) || (w_dx_aluop == ALU_DIV));

`ifdef HAZARD_CTRL_WATCHDOG_EN
  logic [5:0] r_wd_cnt;
  logic       r_md_timeout;

  assign w_wd_expire = (r_state == MD_WAIT) && !md_ready &&
                       (r_wd_cnt == 6'(MD_TIMEOUT - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt     <= 6'd0;
      r_md_timeout <= 1'b0;
    end else begin
      if ((r_state == RUN) && (w_state_next == MD_WAIT)) begin
        r_wd_cnt <= 6'd0;
      end else if (r_state == MD_WAIT) begin
        r_wd_cnt <= r_wd_cnt + 6'd1;
      end
      if (w_wd_expire) begin
        r_md_timeout <= 1'b1;
      end
    end
  end

  assign md_timeout = r_md_timeout;
`else
  assign w_wd_expire = 1'b0;
  assign md_timeout  = 1'b0;
`endif

  logic w_unused_bits;
  assign w_unused_bits = ^{fd_insn[11:7], fd_insn[1:0], dx_insn[21:7], dx_insn[1:0],
                           6'(MD_TIMEOUT)};

  // Outputs are gated by reset_n so they drop the instant reset asserts.
  always_comb begin
    w_state_next  = r_state;
    stall_fd      = 1'b0;
    stall_dx      = 1'b0;
    flush_fd      = 1'b0;
    bubble_dx     = 1'b0;
    bubble_xm     = 1'b0;
    md_start      = 1'b0;
    md_result_sel = 1'b0;
    if (reset_n) begin
      case (r_state)
        RUN: begin
          if (branch_taken) begin
            flush_fd  = 1'b1;
            bubble_dx = 1'b1;
          end else if (w_load_use) begin
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end else if (w_md_op) begin
            md_start     = 1'b1;
            w_state_next = MD_WAIT;
          end
        end
        MD_WAIT: begin
          stall_fd  = 1'b1;
          stall_dx  = 1'b1;
          bubble_xm = 1'b1;
          if (md_ready || w_wd_expire) begin
            w_state_next = MD_DONE;
          end
        end
        MD_DONE: begin
          md_result_sel = 1'b1;
          w_state_next  = RUN;
        end
        default: w_state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

endmodule
